dsp_mac_sequencer: RTL and testbench
====================================

Name: dsp_mac_sequencer

Overview:
Controller that runs one DSP48A1 slice as a multiply-accumulate engine for signed dot products of length N. It accepts a job (start plus length) and streams operand pairs over a valid/ready handshake. It drives the slice's A/B operands, OPMODE and CEP with the correct pipeline alignment, then returns the 48-bit P result over a valid/ready output. It sits between the operand-supplying logic and one DSP48A1 instance configured with A1REG=B1REG=MREG=PREG=1 and A0REG=B0REG=0, with all other CEs tied high.

Parameters:
LEN_W, 8, width of the job length field (max N = 2^LEN_W-1)
PIPE, 2, register stages from the dsp_a/dsp_b outputs to the P-register input (A1/B1 + MREG)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  job request, sampled in IDLE only
len  in  LEN_W  number of operand pairs, sampled with start
busy  out  1  high in any state other than IDLE
in_valid  in  1  operand pair valid
in_ready  out  1  operand pair accepted when in_valid&in_ready
in_a  in  18  signed operand A
in_b  in  18  signed operand B
dsp_a  out  18  to slice A port
dsp_b  out  18  to slice B port
dsp_opmode  out  8  to slice OPMODE
dsp_cep  out  1  to slice CEP
dsp_p  in  48  from slice P port
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid&out_ready
out_p  out  48  dot-product result

Behaviour:
- Reset (rst=0, async): state IDLE; busy, in_ready, out_valid, dsp_cep = 0; dsp_a, dsp_b, out_p = 0; dsp_opmode = 8'h00; tag pipeline and counters cleared. Reset mid-job abandons the job; no partial result is emitted.
- OPMODE constants: OP_MUL = 8'h01 (X=M, Z=0); OP_MAC = 8'h09 (X=M, Z=P); OP_HOLD = 8'h00. Pre-adder, carry-in and post-subtract are never used.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE: if start=1 and len!=0 → LOAD and beat counter = len. If start=1 and len=0 → DONE with out_p=0; the slice is not touched. start is ignored in every other state.
- LOAD: in_ready=1 (registered, high from the cycle after start is accepted). On each accepted beat at edge t: dsp_a/dsp_b <= in_a/in_b; a tag {valid=1, first=(beat is the 1st)} enters a PIPE-deep delay line; the counter decrements. On the last beat → DRAIN, and in_ready drops in the following cycle. A cycle with in_valid=0 pushes a tag with valid=0 (bubble); dsp_a/dsp_b hold.
- Alignment: for a beat accepted at edge t, during the cycle after edge t+PIPE, dsp_cep=1 and dsp_opmode = first ? OP_MUL : OP_MAC. P loads at edge t+PIPE+1. On bubble tags dsp_cep=0 and dsp_opmode=OP_HOLD, so P holds.
- DRAIN: counts PIPE+1 cycles after the last beat. At edge tL+PIPE+2 (tL = last-beat edge), out_p <= dsp_p, out_valid <= 1, state → DONE.
- DONE: out_valid and out_p are held stable until out_valid&out_ready. At that edge out_valid <= 0 and state → IDLE. A new start is accepted from the next cycle.
- Arithmetic: signed 18x18 products, 48-bit accumulation wraps modulo 2^48 as the slice does; no overflow flag.
- in_ready=0 in IDLE, DRAIN and DONE; in_valid is ignored then.

Decomposition:
- Package dsp_ctrl_pkg: OP_MUL/OP_MAC/OP_HOLD constants, state encoding (IDLE, LOAD, DRAIN, DONE), tag struct {valid, first}.
- Sub-module dsp_tag_pipe: a PIPE-deep shift register of tags with async active-low clear. It is the single place that encodes slice latency.

Test Plan:
1. PIPE=2, len=3, back-to-back a={2,3,4}, b={5,6,7} with a behavioural slice model → out_p=56; dsp_opmode sequence 01,09,09 with dsp_cep=1 on three consecutive cycles; out_valid rises at tL+4.
2. len=1, a=-3, b=5 → out_p=48'hFFFF_FFFF_FFF1.
3. len=4, a={1,1,1,1}, b={10,20,30,40}, in_valid low for 2 cycles between beats 2 and 3 → out_p=100; dsp_cep=0 and opmode=00 on exactly the 2 bubble cycles.
4. Result ready, out_ready held low 5 cycles, start pulsed and in_valid high meanwhile → out_valid/out_p stable, in_ready=0, start ignored; after out_ready=1 → IDLE and a next job len=1 (3x3) gives 9.
5. rst=0 after 2 of 4 beats → all outputs 0 immediately (before next edge); after release, job len=2 a={1,2}, b={3,4} → 11, no residue from the aborted job.
6. start with len=0 → out_valid=1 with out_p=0 one cycle later; dsp_cep never asserted.

Source files
------------

// File: rtl/dsp_ctrl_pkg.sv
// dsp_ctrl_pkg: shared opmodes, FSM encoding and pipeline tag type for the DSP MAC sequencer
package dsp_ctrl_pkg;
    localparam logic [7:0] OP_MUL  = 8'h01;
    localparam logic [7:0] OP_MAC  = 8'h09;
    localparam logic [7:0] OP_HOLD = 8'h00;
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
    typedef struct packed {
        logic valid;
        logic first;
    } tag_t;
endpackage

// File: rtl/dsp_tag_pipe.sv
// dsp_tag_pipe: DEPTH-deep tag delay line matching slice operand latency (A1/B1 + MREG)
module dsp_tag_pipe
    import dsp_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  tag_t din,
    output tag_t dout
);
    tag_t stage [DEPTH];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end
    assign dout = stage[DEPTH-1];
endmodule

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: streams operand pairs into one DSP48A1 slice as a signed dot-product MAC
module dsp_mac_sequencer
    import dsp_ctrl_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int PIPE  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      in_a,
    input  logic [17:0]      in_b,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_cep,
    input  logic [47:0]      dsp_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [47:0]      out_p
);
    state_t           state;
    logic [LEN_W-1:0] cnt;
    logic             first;
    logic             accept;
    tag_t             tag_in;
    tag_t             tag_out;
    assign accept = in_valid & in_ready;
    assign tag_in = '{valid: accept, first: first};
    assign busy   = state != IDLE;
    dsp_tag_pipe #(.DEPTH(PIPE)) u_tag_pipe (
        .clk (clk),
        .rst (rst),
        .din (tag_in),
        .dout(tag_out)
    );
    // cep/opmode are registered off the last tag stage, so they land one cycle after it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            first      <= 1'b0;
            in_ready   <= 1'b0;
            dsp_a      <= '0;
            dsp_b      <= '0;
            dsp_cep    <= 1'b0;
            dsp_opmode <= OP_HOLD;
            out_valid  <= 1'b0;
            out_p      <= '0;
        end else begin
            dsp_cep    <= tag_out.valid;
            dsp_opmode <= tag_out.valid ? (tag_out.first ? OP_MUL : OP_MAC) : OP_HOLD;
            case (state)
                IDLE: if (start) begin
                    if (len != '0) begin
                        state    <= LOAD;
                        cnt      <= len;
                        first    <= 1'b1;
                        in_ready <= 1'b1;
                    end else begin
                        state     <= DONE;
                        out_p     <= '0;
                        out_valid <= 1'b1;
                    end
                end
                LOAD: if (accept) begin
                    dsp_a <= in_a;
                    dsp_b <= in_b;
                    first <= 1'b0;
                    cnt   <= cnt - 1'b1;
                    if (cnt == LEN_W'(1)) begin
                        state    <= DRAIN;
                        in_ready <= 1'b0;
                        cnt      <= LEN_W'(PIPE + 1);
                    end
                end
                DRAIN: if (cnt == '0) begin
                    out_p     <= dsp_p;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer: directed checks of the MAC sequencer against a behavioural DSP48A1 slice
module tb_dsp_mac_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        busy;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] in_a = '0;
    logic [17:0] in_b = '0;
    logic [17:0] dsp_a;
    logic [17:0] dsp_b;
    logic [7:0]  dsp_opmode;
    logic        dsp_cep;
    logic [47:0] dsp_p;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [47:0] out_p;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cep_count = 0;
    int          snap;
    logic signed [17:0] a1, b1;
    logic signed [47:0] m, p;

    always #5 clk = ~clk;

    dsp_mac_sequencer #(.LEN_W(8), .PIPE(2)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_cep(dsp_cep),
        .dsp_p(dsp_p), .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p)
    );

    // A1/B1 -> MREG -> PREG, X=M and Z=P/0 selected by opmode
    always @(posedge clk) begin
        a1 <= dsp_a;
        b1 <= dsp_b;
        m  <= a1 * b1;
        if (dsp_cep) begin
            p <= (dsp_opmode == 8'h09) ? p + m : (dsp_opmode == 8'h01) ? m : p;
            cep_count <= cep_count + 1;
        end
    end
    assign dsp_p = p;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [7:0] n);
        start = 1'b1;
        len   = n;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [17:0] a, input logic [17:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [47:0] exp);
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk(tag, 64'(out_p), 64'(exp));
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("release_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_cep", 64'(dsp_cep), 64'd0);
        chk("rst_opmode", 64'(dsp_opmode), 64'h00);
        chk("rst_out_p", 64'(out_p), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // job 1: 2*5 + 3*6 + 4*7 = 56, back-to-back beats
        go(8'd3);
        chk("t1_in_ready", 64'(in_ready), 64'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        beat(18'd2, 18'd5);
        beat(18'd3, 18'd6);
        beat(18'd4, 18'd7);
        chk("t1_in_ready_drop", 64'(in_ready), 64'd0);
        chk("t1_op0", {dsp_cep, dsp_opmode}, {1'b1, 8'h01});
        tick();
        chk("t1_op1", {dsp_cep, dsp_opmode}, {1'b1, 8'h09});
        tick();
        chk("t1_op2", {dsp_cep, dsp_opmode}, {1'b1, 8'h09});
        tick();
        chk("t1_op3", {dsp_cep, dsp_opmode}, {1'b0, 8'h00});
        chk("t1_valid_tl3", 64'(out_valid), 64'd0);
        tick();
        chk("t1_valid_tl4", 64'(out_valid), 64'd1);
        chk("t1_out_p", 64'(out_p), 64'd56);
        release_result();

        // job 2: -3 * 5 = -15
        go(8'd1);
        beat(18'h3FFFD, 18'd5);
        wait_result("t2_out_p", 48'hFFFF_FFFF_FFF1);
        release_result();

        // job 3: two bubble cycles between beats 2 and 3
        go(8'd4);
        beat(18'd1, 18'd10);
        beat(18'd1, 18'd20);
        tick();
        chk("t3_op_b1", {dsp_cep, dsp_opmode}, {1'b1, 8'h01});
        tick();
        chk("t3_op_b2", {dsp_cep, dsp_opmode}, {1'b1, 8'h09});
        beat(18'd1, 18'd30);
        chk("t3_bubble0", {dsp_cep, dsp_opmode}, {1'b0, 8'h00});
        beat(18'd1, 18'd40);
        chk("t3_bubble1", {dsp_cep, dsp_opmode}, {1'b0, 8'h00});
        tick();
        chk("t3_op_b3", {dsp_cep, dsp_opmode}, {1'b1, 8'h09});
        tick();
        chk("t3_op_b4", {dsp_cep, dsp_opmode}, {1'b1, 8'h09});
        wait_result("t3_out_p", 48'd100);
        release_result();

        // job 4: 5*7 + (-1)*3 = 32, result held while out_ready is low
        go(8'd2);
        beat(18'd5, 18'd7);
        beat(18'h3FFFF, 18'd3);
        wait_result("t4_out_p", 48'd32);
        start    = 1'b1;
        len      = 8'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_valid", 64'(out_valid), 64'd1);
            chk("t4_hold_p", 64'(out_p), 64'd32);
            chk("t4_hold_in_ready", 64'(in_ready), 64'd0);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        release_result();
        go(8'd1);
        beat(18'd3, 18'd3);
        wait_result("t4_next", 48'd9);
        release_result();

        // job 5: reset after two of four beats
        go(8'd4);
        beat(18'd1, 18'd1);
        beat(18'd2, 18'd2);
        #2 rst = 1'b0;
        #1;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_in_ready", 64'(in_ready), 64'd0);
        chk("t5_cep_op", {dsp_cep, dsp_opmode}, {1'b0, 8'h00});
        chk("t5_dsp_ab", {dsp_a, dsp_b}, 64'd0);
        chk("t5_out", {out_valid, out_p}, 64'd0);
        tick();
        tick();
        rst = 1'b1;
        go(8'd2);
        beat(18'd1, 18'd3);
        beat(18'd2, 18'd4);
        wait_result("t5_out_p", 48'd11);
        release_result();

        // job 6: zero length never touches the slice
        tick();
        snap = cep_count;
        go(8'd0);
        chk("t6_valid", 64'(out_valid), 64'd1);
        chk("t6_out_p", 64'(out_p), 64'd0);
        repeat (3) tick();
        release_result();
        repeat (3) tick();
        chk("t6_no_cep", 64'(cep_count - snap), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
